// File: rtl/gst_video_pkg.sv
// Shared video-path types: horizontal timing record, mode encodings and
// the fixed per-mode timing tables.
package gst_video_pkg;

  localparam int          HT_CW      = 8;
  localparam int          MODE_W     = 2;
  localparam int unsigned HT_LEN_MAX = 1 << HT_CW;

  localparam logic [MODE_W-1:0] MODE_PAL  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_NTSC = 2'd1;
  localparam logic [MODE_W-1:0] MODE_MONO = 2'd2;
  localparam logic [MODE_W-1:0] MODE_PROG = 2'd3;

  // len uses the same encoding as p_len: 0 stands for a full 2^HT_CW line.
  typedef struct packed {
    logic [HT_CW-1:0] len;
    logic [HT_CW-1:0] hs_start;
    logic [HT_CW-1:0] hs_end;
    logic [HT_CW-1:0] hb_start;
    logic [HT_CW-1:0] hb_end;
    logic [HT_CW-1:0] de_start;
    logic [HT_CW-1:0] de_end;
  } htiming_t;

  function automatic htiming_t mk_timing(input int unsigned len,
                                         input int unsigned hs_s, input int unsigned hs_e,
                                         input int unsigned hb_s, input int unsigned hb_e,
                                         input int unsigned de_s, input int unsigned de_e);
    htiming_t    t;
    int unsigned sat;
    sat        = (len > HT_LEN_MAX) ? HT_LEN_MAX : len;
    t.len      = HT_CW'(sat);
    if (t.len == HT_CW'(1)) t.len = HT_CW'(2);
    t.hs_start = HT_CW'(hs_s);
    t.hs_end   = HT_CW'(hs_e);
    t.hb_start = HT_CW'(hb_s);
    t.hb_end   = HT_CW'(hb_e);
    t.de_start = HT_CW'(de_s);
    t.de_end   = HT_CW'(de_e);
    return t;
  endfunction

  // Programmable mode is resolved by the caller from its p_* inputs.
  function automatic htiming_t htiming_lookup(input logic [MODE_W-1:0] mode,
                                              input logic interlace);
    htiming_t t;
    case (mode)
      MODE_NTSC: t = mk_timing(interlace ? 128 : 127, 100, 110, 95, 15, 19, 95);
      MODE_MONO: t = mk_timing(112, 94, 104, 90, 8, 10, 90);
      default:   t = mk_timing(interlace ? 129 : 128, 101, 111, 96, 16, 20, 96);
    endcase
    return t;
  endfunction

endpackage

// File: rtl/win_sr.sv
// Registered set/reset window flop: start match enters the window, end match
// leaves it, start wins on a simultaneous match.
module win_sr #(
  parameter logic RST_VAL    = 1'b0,
  parameter logic ACTIVE_LOW = 1'b0
) (
  input  logic m2clock,
  input  logic res,
  input  logic ce,
  input  logic start_hit,
  input  logic end_hit,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge m2clock) begin
    if (res) begin
      q <= RST_VAL;
    end else if (ce) begin
      if (start_hit)    q <= ~ACTIVE_LOW;
      else if (end_hit) q <= ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/hsync_timing_gen.sv
// Parametrised horizontal timing generator: line counter, sync/blank/DE
// windows and line-end strobe, with mode changes applied only at line wrap.
module hsync_timing_gen
  import gst_video_pkg::*;
#(
  parameter int CW      = HT_CW,
  parameter int NMODE_W = MODE_W
) (
  input  logic               m2clock,
  input  logic               res,
  input  logic               ce,
  input  logic [NMODE_W-1:0] mode,
  input  logic               interlace,
  input  logic [CW-1:0]      p_len,
  input  logic [CW-1:0]      p_hs_start,
  input  logic [CW-1:0]      p_hs_end,
  input  logic [CW-1:0]      p_hb_start,
  input  logic [CW-1:0]      p_hb_end,
  input  logic [CW-1:0]      p_de_start,
  input  logic [CW-1:0]      p_de_end,
  output logic [CW-1:0]      hcount,
  output logic               hsync_n,
  output logic               hblank,
  output logic               de,
  output logic               vertclk,
  output logic [NMODE_W-1:0] mode_act
);

  htiming_t      shadow_q;
  htiming_t      timing_nxt;
  logic [CW-1:0] hcount_q;
  logic [CW-1:0] last_hc;
  logic          wrap;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    timing_nxt = htiming_lookup(mode, interlace);
    if (mode == MODE_PROG) begin
      timing_nxt.len      = (p_len == CW'(1)) ? CW'(2) : p_len;
      timing_nxt.hs_start = p_hs_start;
      timing_nxt.hs_end   = p_hs_end;
      timing_nxt.hb_start = p_hb_start;
      timing_nxt.hb_end   = p_hb_end;
      timing_nxt.de_start = p_de_start;
      timing_nxt.de_end   = p_de_end;
    end
  end

  // A stored len of 0 means 2^CW, so len-1 naturally wraps to all ones.
  assign last_hc = shadow_q.len - CW'(1);
  assign wrap    = ce && (hcount_q == last_hc);

  always_ff @(posedge m2clock) begin
    if (res) begin
      hcount_q <= '0;
      shadow_q <= timing_nxt;
      mode_act <= mode;
    end else if (ce) begin
      if (wrap) begin
        hcount_q <= '0;
        shadow_q <= timing_nxt;
        mode_act <= mode;
      end else begin
        hcount_q <= hcount_q + CW'(1);
      end
    end
  end

  win_sr #(.RST_VAL(1'b1), .ACTIVE_LOW(1'b1)) u_hsync (
    .m2clock   (m2clock),
    .res       (res),
    .ce        (ce),
    .start_hit (hcount_q == shadow_q.hs_start),
    .end_hit   (hcount_q == shadow_q.hs_end),
    .q         (hsync_n)
  );

  win_sr #(.RST_VAL(1'b1), .ACTIVE_LOW(1'b0)) u_hblank (
    .m2clock   (m2clock),
    .res       (res),
    .ce        (ce),
    .start_hit (hcount_q == shadow_q.hb_start),
    .end_hit   (hcount_q == shadow_q.hb_end),
    .q         (hblank)
  );

  win_sr #(.RST_VAL(1'b0), .ACTIVE_LOW(1'b0)) u_de (
    .m2clock   (m2clock),
    .res       (res),
    .ce        (ce),
    .start_hit (hcount_q == shadow_q.de_start),
    .end_hit   (hcount_q == shadow_q.de_end),
    .q         (de)
  );

  assign hcount  = hcount_q;
  assign vertclk = wrap && !res;

endmodule

// File: tb/tb_hsync_timing_gen.sv
// Directed bench for hsync_timing_gen: expected outputs come from the
// hand-written window rules and timing tables below.
module tb_hsync_timing_gen;

  typedef struct {
    int len;
    int hs_s, hs_e;
    int hb_s, hb_e;
    int de_s, de_e;
  } tm_t;

  tm_t t_pal   = '{128, 101, 111, 96, 16, 20, 96};
  tm_t t_mono  = '{112, 94, 104, 90, 8, 10, 90};
  tm_t t_ntsc  = '{127, 100, 110, 95, 15, 19, 95};
  tm_t t_ntsci = '{128, 100, 110, 95, 15, 19, 95};
  tm_t t_prog  = '{256, 10, 10, 200, 20, 30, 150};
  tm_t t_prog2 = '{2, 10, 10, 200, 20, 30, 150};

  logic       m2clock = 1'b0;
  logic       res, ce, interlace;
  logic [1:0] mode;
  logic [7:0] p_len, p_hs_start, p_hs_end, p_hb_start, p_hb_end, p_de_start, p_de_end;
  logic [7:0] hcount;
  logic       hsync_n, hblank, de, vertclk;
  logic [1:0] mode_act;

  int n_checks = 0;
  int n_pass   = 0;

  hsync_timing_gen dut (
    .m2clock    (m2clock),
    .res        (res),
    .ce         (ce),
    .mode       (mode),
    .interlace  (interlace),
    .p_len      (p_len),
    .p_hs_start (p_hs_start),
    .p_hs_end   (p_hs_end),
    .p_hb_start (p_hb_start),
    .p_hb_end   (p_hb_end),
    .p_de_start (p_de_start),
    .p_de_end   (p_de_end),
    .hcount     (hcount),
    .hsync_n    (hsync_n),
    .hblank     (hblank),
    .de         (de),
    .vertclk    (vertclk),
    .mode_act   (mode_act)
  );

  always #5 m2clock = ~m2clock;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  // A start==end window is entered once and never left, so it is only
  // inactive on its first line up to and including the match count.
  task automatic chk_state(input string tag, input int h, input tm_t t, input int mact,
                           input bit ce_on, input bit first_line);
    int e_hs, e_hb, e_de, e_vc;
    if (t.hs_s == t.hs_e) e_hs = (first_line && h <= t.hs_s) ? 1 : 0;
    else                  e_hs = (h > t.hs_s && h <= t.hs_e) ? 0 : 1;
    e_hb = (h > t.hb_e && h <= t.hb_s) ? 0 : 1;
    e_de = (h > t.de_s && h <= t.de_e) ? 1 : 0;
    e_vc = (ce_on && h == t.len - 1) ? 1 : 0;
    check({tag, "_hcount"},   int'(hcount),   h);
    check({tag, "_hsync_n"},  int'(hsync_n),  e_hs);
    check({tag, "_hblank"},   int'(hblank),   e_hb);
    check({tag, "_de"},       int'(de),       e_de);
    check({tag, "_vertclk"},  int'(vertclk),  e_vc);
    check({tag, "_mode_act"}, int'(mode_act), mact);
  endtask

  task automatic run_chk(input string tag, input int n, input int start, input tm_t t,
                         input int mact, input bit first_line);
    for (int k = 0; k < n; k++) begin
      #1;
      chk_state(tag, (start + k) % t.len, t, mact, 1'b1, first_line);
      @(negedge m2clock);
    end
  endtask

  task automatic freeze(input string tag, input int n, input int h, input tm_t t, input int mact);
    ce = 1'b0;
    for (int k = 0; k < n; k++) begin
      #1;
      chk_state(tag, h, t, mact, 1'b0, 1'b0);
      @(negedge m2clock);
    end
    ce = 1'b1;
  endtask

  initial begin
    res = 1'b1; ce = 1'b1; mode = 2'd0; interlace = 1'b0;
    p_len = '0; p_hs_start = '0; p_hs_end = '0;
    p_hb_start = '0; p_hb_end = '0; p_de_start = '0; p_de_end = '0;

    @(negedge m2clock);
    #1;
    check("rst_hcount",   int'(hcount),   0);
    check("rst_hsync_n",  int'(hsync_n),  1);
    check("rst_hblank",   int'(hblank),   1);
    check("rst_de",       int'(de),       0);
    check("rst_vertclk",  int'(vertclk),  0);
    check("rst_mode_act", int'(mode_act), 0);
    res = 1'b0;

    // PAL: 300 cycles from reset, period 128.
    run_chk("pal", 300, 0, t_pal, 0, 1'b0);
    run_chk("pal", 6, 44, t_pal, 0, 1'b0);

    // Switch to mono at hcount 50: the PAL line completes first.
    mode = 2'd2;
    run_chk("pal_tail", 78, 50, t_pal, 0, 1'b0);
    run_chk("mono", 224, 0, t_mono, 2, 1'b0);

    // NTSC with interlace (period 128), then without (period 127).
    mode = 2'd1; interlace = 1'b1;
    run_chk("mono_tail", 112, 0, t_mono, 2, 1'b0);
    run_chk("ntsc_il", 256, 0, t_ntsci, 1, 1'b0);
    interlace = 1'b0;
    run_chk("ntsc_il_tail", 128, 0, t_ntsci, 1, 1'b0);
    run_chk("ntsc", 254, 0, t_ntsc, 1, 1'b0);

    // ce pattern 1,0,0,1 inside the sync pulse and on the last count.
    run_chk("ntsc_pre_ce", 105, 0, t_ntsc, 1, 1'b0);
    freeze("ce_hold_sync", 2, 105, t_ntsc, 1);
    run_chk("ntsc_mid_ce", 21, 105, t_ntsc, 1, 1'b0);
    freeze("ce_hold_last", 2, 126, t_ntsc, 1);
    run_chk("ntsc_last", 1, 126, t_ntsc, 1, 1'b0);

    // Reset while hsync_n is low; reset loads programmable timing.
    run_chk("ntsc_pre_res", 105, 0, t_ntsc, 1, 1'b0);
    mode = 2'd3; p_len = 8'd0;
    p_hs_start = 8'd10;  p_hs_end = 8'd10;
    p_hb_start = 8'd200; p_hb_end = 8'd20;
    p_de_start = 8'd30;  p_de_end = 8'd150;
    res = 1'b1;
    #1;
    check("pre_res_hsync_n", int'(hsync_n), 0);
    check("in_res_vertclk",  int'(vertclk), 0);
    @(negedge m2clock);
    #1;
    check("res2_hcount",   int'(hcount),   0);
    check("res2_hsync_n",  int'(hsync_n),  1);
    check("res2_hblank",   int'(hblank),   1);
    check("res2_de",       int'(de),       0);
    check("res2_vertclk",  int'(vertclk),  0);
    check("res2_mode_act", int'(mode_act), 3);
    res = 1'b0;

    // p_len=0 -> 256-count line; hs start==end stays low from hcount 11.
    run_chk("prog256_l1", 256, 0, t_prog, 3, 1'b1);
    p_len = 8'd1;
    run_chk("prog256_l2", 256, 0, t_prog, 3, 1'b0);
    // p_len=1 clamps to 2: vertclk every other cycle, out-of-range edges never fire.
    run_chk("prog_clamp", 8, 0, t_prog2, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
